generador_secuencia: RTL and testbench
======================================

# generador_secuencia

Serial pattern source for the sequence-detector path. It accepts parallel words through a valid/ready handshake and shifts each word out MSB-first on a single serial line `dato`. Each bit is held for `DIV` clock cycles, so the output rate matches the detector's divided sampling clock. It is the transmit end of the serial line the detector listens on, and it is used on-chip and as a synthesizable stimulus source in benches.

## Interface
Parameters:
- `ANCHO`, default 8: word width in bits; legal range 2..32.
- `DIV`, default 2: clk cycles per serial bit; legal range 1..16.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: reset, synchronous and active-high.
- `palabra`, input, `ANCHO`: word to transmit; sampled only on an accepted handshake.
- `valido`, input, 1: `palabra` is valid.
- `listo`, output, 1: ready to accept a word.
- `dato`, output, 1: serial output, registered.
- `transmitiendo`, output, 1: a frame is in progress.
- `fin`, output, 1: one-cycle pulse in the final cycle of a frame.

## Operation
- Handshake: a word is accepted on a rising edge where `valido && listo`. `palabra` is copied into a shift register at that edge. Later changes to `palabra` have no effect on the frame.
- `valido` while `listo=0` is ignored. The word is not queued.
- FSM states:
  - REPOSO: `dato=0`, `transmitiendo=0`, `listo=1`. On accept, go to ENVIO.
  - ENVIO: bits go out MSB-first. A bit counter runs 0..`ANCHO`-1 and a tick counter runs 0..`DIV`-1. Shift when the tick counter wraps. After the last bit, go to PARIDAD if that feature is compiled in (see Configuration), otherwise to REPOSO.
  - PARIDAD: drives the parity bit for `DIV` cycles, then goes to REPOSO.
- Back-to-back frames:
  - `listo` is also 1 in the final cycle of a frame, the same cycle `fin=1`.
  - An accept in that cycle goes directly to ENVIO with the new word, with no idle gap on `dato`.
  - If there is no accept, the FSM returns to REPOSO.
- Tick counter restarts at 0 on every accept.
- Reset:
  - While `reset=1`: `listo=0`, `dato=0`, `transmitiendo=0`, `fin=0`, FSM in REPOSO, counters 0.
  - Reset in mid-frame aborts the frame with no `fin` pulse.
  - `valido` is ignored during reset.

## Timing
- Accept at edge k means `dato` = MSB and `transmitiendo=1` starting in the cycle after edge k.
- Bit i (MSB = i=0) is valid from edge k+i·`DIV` to edge k+(i+1)·`DIV`.
- Frame length is `ANCHO`·`DIV` cycles, plus `DIV` when parity is enabled.
- `fin` is high for exactly one cycle: the last cycle of the last bit.
- First `listo=1` comes in the cycle after the edge where `reset` is sampled low.
- With `DIV=1`, a new bit appears every cycle, and `fin` and `listo` coincide with that single bit cycle.
- Reset values: `listo=0`, `dato=0`, `transmitiendo=0`, `fin=0`.

## Configuration
- Macro `GENERADOR_SECUENCIA_PARIDAD_EN`.
- Defined: the PARIDAD state exists. One extra bit equal to the XOR of all `ANCHO` data bits (even parity) is appended for `DIV` cycles. `fin` moves to the last cycle of the parity bit.
- Undefined: no PARIDAD state and no parity logic. The frame is data bits only.

## Structure
- Package `generador_secuencia_pkg`:
  - state enum (REPOSO, ENVIO, PARIDAD);
  - width constants derived from the parameters, `$clog2(ANCHO)` and `$clog2(DIV)`;
  - legal-range limits for `ANCHO` and `DIV`.
- Sub-module `habilitador_bit`: the `DIV` tick counter. It takes `clk`, `reset` and a restart input, and outputs a one-cycle `tick` at count `DIV`-1. It is the synchronous-enable counterpart of the clock divider; no derived clocks are used.

## Test plan
- Single word, `ANCHO=8`, `DIV=2`, `palabra=8'hA5` accepted at edge 0:
  - `dato` = 1,0,1,0,0,1,0,1, each bit held 2 cycles over cycles 1–16;
  - `fin=1` in cycle 16 only;
  - `transmitiendo` falls after cycle 16.
- Back-to-back: `8'hFF`, then `8'h00` offered with `valido` held high:
  - second accept occurs in the `fin` cycle of the first frame;
  - `dato` is 16 cycles of 1 followed immediately by 16 cycles of 0, with no gap.
- Busy ignore: `valido` pulsed with `8'h3C` at cycle 5 of an `8'hA5` frame:
  - `listo=0` at that edge;
  - `8'hA5` frame completes unchanged;
  - no second frame follows.
- Reset mid-frame: `reset=1` at cycle 7 of an `8'hA5` frame:
  - next cycle `dato=0`, `transmitiendo=0`, `listo=0`;
  - no `fin` pulse;
  - `listo=1` in the first cycle after reset release.
- Parity build, `palabra=8'h07`: 8 data bits, then parity bit 1 for 2 cycles; `fin` in cycle 18.
- `DIV=1`, `ANCHO=4`, `palabra=4'b1001`: `dato` = 1,0,0,1 in cycles 1–4; `fin` in cycle 4.

Source files
------------

// File: rtl/generador_secuencia_pkg.sv
// Shared types, width helper and legal parameter limits for generador_secuencia.
// Macro GENERADOR_SECUENCIA_PARIDAD_EN adds the PARIDAD state.
package generador_secuencia_pkg;

    localparam int ANCHO_MIN = 2;
    localparam int ANCHO_MAX = 32;
    localparam int DIV_MIN   = 1;
    localparam int DIV_MAX   = 16;

`ifdef GENERADOR_SECUENCIA_PARIDAD_EN
    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        ENVIO   = 2'd1,
        PARIDAD = 2'd2
    } estado_t;
`else
    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        ENVIO   = 2'd1
    } estado_t;
`endif

    // $clog2(n), widened to one bit so a count of 1 still gets a real register.
    function automatic int cnt_ancho(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/generador_secuencia_habilitador_bit.sv
// Bit-period tick counter: free-running 0..DIV-1, restartable, one-cycle tick at DIV-1.
// Replaces a divided clock with a synchronous enable.
module habilitador_bit
    import generador_secuencia_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic reiniciar,
    output logic tick
);

    localparam int W = cnt_ancho(DIV);

    logic [W-1:0] cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q + W'(1);
        if (reiniciar || cuenta_q == W'(DIV - 1))
            cuenta_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cuenta_q <= '0;
        else       cuenta_q <= cuenta_d;
    end

    assign tick = (cuenta_q == W'(DIV - 1));

endmodule

// File: rtl/generador_secuencia.sv
// Serial pattern source: parallel word in by valid/ready, shifted out MSB-first, DIV clocks per bit.
// Macro GENERADOR_SECUENCIA_PARIDAD_EN appends an even-parity bit to each frame.
module generador_secuencia
    import generador_secuencia_pkg::*;
#(
    parameter int ANCHO = 8,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ANCHO-1:0] palabra,
    input  logic             valido,
    output logic             listo,
    output logic             dato,
    output logic             transmitiendo,
    output logic             fin
);

    localparam int BIT_W = cnt_ancho(ANCHO);

    if (ANCHO < ANCHO_MIN || ANCHO > ANCHO_MAX || DIV < DIV_MIN || DIV > DIV_MAX) begin : g_rango
        $error("generador_secuencia: ANCHO or DIV out of range");
    end

    estado_t            estado_q, estado_d;
    logic [ANCHO-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               dato_q, dato_d;
    logic               arranque_q;
    logic               tick;
    logic               aceptar;
    logic               ultimo_bit;
`ifdef GENERADOR_SECUENCIA_PARIDAD_EN
    logic               par_q, par_d;
`endif

    habilitador_bit #(.DIV(DIV)) u_habilitador (
        .clk       (clk),
        .reset     (reset),
        .reiniciar (aceptar),
        .tick      (tick)
    );

    assign ultimo_bit = (bit_q == BIT_W'(ANCHO - 1));

`ifdef GENERADOR_SECUENCIA_PARIDAD_EN
    assign fin = (estado_q == PARIDAD) && tick;
`else
    assign fin = (estado_q == ENVIO) && tick && ultimo_bit;
`endif

    // arranque_q holds listo low for the whole reset and the cycle it is released in.
    assign listo         = arranque_q && ((estado_q == REPOSO) || fin);
    assign aceptar       = valido && listo;
    assign transmitiendo = (estado_q != REPOSO);
    assign dato          = dato_q;

    always_comb begin
        estado_d = estado_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        dato_d   = dato_q;
`ifdef GENERADOR_SECUENCIA_PARIDAD_EN
        par_d    = par_q;
`endif
        case (estado_q)
            ENVIO: begin
                if (tick) begin
                    if (ultimo_bit) begin
`ifdef GENERADOR_SECUENCIA_PARIDAD_EN
                        estado_d = PARIDAD;
                        dato_d   = par_q;
`else
                        estado_d = REPOSO;
                        dato_d   = 1'b0;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q << 1;
                        dato_d  = shift_q[ANCHO-2];
                    end
                end
            end
`ifdef GENERADOR_SECUENCIA_PARIDAD_EN
            PARIDAD: begin
                if (tick) begin
                    estado_d = REPOSO;
                    dato_d   = 1'b0;
                end
            end
`endif
            default: begin
                estado_d = REPOSO;
                dato_d   = 1'b0;
            end
        endcase

        // An accept in the final cycle overrides the return to REPOSO, so frames abut.
        if (aceptar) begin
            estado_d = ENVIO;
            shift_d  = palabra;
            bit_d    = '0;
            dato_d   = palabra[ANCHO-1];
`ifdef GENERADOR_SECUENCIA_PARIDAD_EN
            par_d    = ^palabra;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= REPOSO;
            shift_q    <= '0;
            bit_q      <= '0;
            dato_q     <= 1'b0;
            arranque_q <= 1'b0;
`ifdef GENERADOR_SECUENCIA_PARIDAD_EN
            par_q      <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            dato_q     <= dato_d;
            arranque_q <= 1'b1;
`ifdef GENERADOR_SECUENCIA_PARIDAD_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_generador_secuencia.sv
// Directed bench for generador_secuencia: ANCHO=8/DIV=2 instance plus an ANCHO=4/DIV=1 instance.
module tb_generador_secuencia;

`ifdef GENERADOR_SECUENCIA_PARIDAD_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F0 = 16 + 2 * PAR;   // frame length, ANCHO=8 DIV=2
    localparam int F1 = 4 + PAR;        // frame length, ANCHO=4 DIV=1

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] palabra0;
    logic       valido0;
    logic       listo0, dato0, trans0, fin0;
    logic [3:0] palabra1;
    logic       valido1;
    logic       listo1, dato1, trans1, fin1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    generador_secuencia #(.ANCHO(8), .DIV(2)) u0 (
        .clk(clk), .reset(reset), .palabra(palabra0), .valido(valido0),
        .listo(listo0), .dato(dato0), .transmitiendo(trans0), .fin(fin0)
    );

    generador_secuencia #(.ANCHO(4), .DIV(1)) u1 (
        .clk(clk), .reset(reset), .palabra(palabra1), .valido(valido1),
        .listo(listo1), .dato(dato1), .transmitiendo(trans1), .fin(fin1)
    );

    typedef struct {
        logic [7:0]  palabra;
        logic [15:0] forma;    // dato per cycle 1..16, cycle 1 in bit 15
        logic        paridad;
    } vector_t;

    vector_t tabla [5];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic esperar_listo0();
        int guard = 0;
        @(negedge clk);
        while (!listo0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("listo_before_accept", listo0, 1'b1);
    endtask

    // One frame on u0; busy_at pulses valido in that cycle, rst_at resets in that cycle.
    task automatic frame_u0(input logic [7:0] w, input logic [15:0] forma, input logic p,
                            input int busy_at, input int rst_at);
        logic esp;
        logic fin_visto;
        esperar_listo0();
        palabra0 = w;
        valido0  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= F0; c++) begin
            @(negedge clk);
            if (c == 1) palabra0 = 8'h5A;
            esp = (c <= 16) ? forma[16 - c] : p;
            chk($sformatf("dato_w%02h_c%0d", w, c), dato0, esp);
            chk($sformatf("trans_w%02h_c%0d", w, c), trans0, 1'b1);
            chk($sformatf("fin_w%02h_c%0d", w, c), fin0, (c == F0));
            if (c == busy_at) begin
                chk("listo_busy", listo0, 1'b0);
                valido0  = 1'b1;
                palabra0 = 8'h3C;
            end else begin
                valido0 = 1'b0;
            end
            if (c == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk("rst_mid_dato", dato0, 1'b0);
                chk("rst_mid_trans", trans0, 1'b0);
                chk("rst_mid_listo", listo0, 1'b0);
                chk("rst_mid_fin", fin0, 1'b0);
                reset = 1'b0;
                @(negedge clk);
                chk("rst_release_listo", listo0, 1'b1);
                fin_visto = 1'b0;
                for (int k = 0; k < F0; k++) begin
                    @(negedge clk);
                    fin_visto |= fin0 | trans0;
                end
                chk("rst_no_fin_after_abort", fin_visto, 1'b0);
                return;
            end
        end
        @(negedge clk);
        chk($sformatf("idle_trans_w%02h", w), trans0, 1'b0);
        chk($sformatf("idle_dato_w%02h", w), dato0, 1'b0);
        chk($sformatf("idle_listo_w%02h", w), listo0, 1'b1);
    endtask

    initial begin
        logic esp;
        logic extra;

        tabla[0] = '{8'hA5, 16'hCC33, 1'b0};
        tabla[1] = '{8'h3C, 16'h0FF0, 1'b0};
        tabla[2] = '{8'h07, 16'h003F, 1'b1};
        tabla[3] = '{8'h80, 16'hC000, 1'b1};
        tabla[4] = '{8'h01, 16'h0003, 1'b1};

        reset    = 1'b1;
        valido0  = 1'b1;   // must be ignored while in reset
        palabra0 = 8'hFF;
        valido1  = 1'b0;
        palabra1 = 4'h0;

        repeat (3) @(negedge clk);
        chk("rst_listo", listo0, 1'b0);
        chk("rst_dato", dato0, 1'b0);
        chk("rst_trans", trans0, 1'b0);
        chk("rst_fin", fin0, 1'b0);
        chk("rst_listo_u1", listo1, 1'b0);
        chk("rst_trans_u1", trans1, 1'b0);
        reset   = 1'b0;
        valido0 = 1'b0;
        chk("release_cycle_listo", listo0, 1'b0);
        @(negedge clk);
        chk("first_listo", listo0, 1'b1);
        chk("first_listo_trans", trans0, 1'b0);

        for (int i = 0; i < 5; i++)
            frame_u0(tabla[i].palabra, tabla[i].forma, tabla[i].paridad, 0, 0);

        // Back-to-back: FF then 00 with valido held; second accept lands in the fin cycle.
        esperar_listo0();
        palabra0 = 8'hFF;
        valido0  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 2 * F0; c++) begin
            @(negedge clk);
            if (c == 1) palabra0 = 8'h00;
            esp = (c <= 16);
            chk($sformatf("b2b_dato_c%0d", c), dato0, esp);
            chk($sformatf("b2b_trans_c%0d", c), trans0, 1'b1);
            chk($sformatf("b2b_fin_c%0d", c), fin0, (c == F0) || (c == 2 * F0));
            if (c == F0) chk("b2b_listo_in_fin", listo0, 1'b1);
            if (c == F0 + 1) valido0 = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle_trans", trans0, 1'b0);

        // Busy ignore: 3C offered at cycle 5 of an A5 frame.
        frame_u0(8'hA5, 16'hCC33, 1'b0, 5, 0);
        extra = 1'b0;
        repeat (20) begin
            @(negedge clk);
            extra |= trans0;
        end
        chk("busy_no_second_frame", extra, 1'b0);

        // Reset at cycle 7 of an A5 frame.
        frame_u0(8'hA5, 16'hCC33, 1'b0, 0, 7);

        // DIV=1, ANCHO=4: 1001 -> 1,0,0,1 then parity 0 if enabled.
        @(negedge clk);
        chk("u1_listo_idle", listo1, 1'b1);
        palabra1 = 4'b1001;
        valido1  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= F1; c++) begin
            @(negedge clk);
            valido1  = 1'b0;
            palabra1 = 4'b0110;
            esp = (c == 1) || (c == 4);
            chk($sformatf("u1_dato_c%0d", c), dato1, esp);
            chk($sformatf("u1_trans_c%0d", c), trans1, 1'b1);
            chk($sformatf("u1_fin_c%0d", c), fin1, (c == F1));
            chk($sformatf("u1_listo_c%0d", c), listo1, (c == F1));
        end
        @(negedge clk);
        chk("u1_idle_trans", trans1, 1'b0);
        chk("u1_idle_dato", dato1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
